// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receive path: parity modes,
// receiver FSM states and the baud divider helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    return clk_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock tick every DIV clocks; a
// synchronous clear restarts the phase so a receiver can align to an edge.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_16x.sv
// 8N1-style UART receiver with 16x oversampling, mid-bit sampling,
// false-start rejection, framing/parity checks and a valid/ready output.
module uart_rx_16x
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] SAMP_MID  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SAMP_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);

  rx_state_e      state_q, state_d;
  logic           rx_meta_q, rx_meta_d;
  logic           rx_s_q, rx_s_d;
  logic [SCW-1:0] samp_q, samp_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [7:0]     data_q, data_d;
  logic           perr_q, perr_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           ovr_q, ovr_d;
  logic           tick, tick_clr;
  logic           par_bad;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // Unused MSBs of shift_q are cleared at frame start, so they do not disturb the XOR.
  assign par_bad = ((^shift_q) ^ par_q) != (PARITY == PAR_ODD);

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    samp_d    = samp_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    perr_d    = perr_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    tick_clr  = 1'b0;

    if (valid_q && data_ready) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        samp_d = '0;
        if (!rx_s_q) begin
          state_d  = START;
          tick_clr = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (samp_q == SAMP_MID) begin
            if (rx_s_q) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              samp_d  = '0;
              bit_d   = '0;
              shift_d = '0;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (samp_q == SAMP_LAST) begin
            samp_d          = '0;
            shift_d[bit_q]  = rx_s_q;
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (tick) begin
          if (samp_q == SAMP_LAST) begin
            samp_d  = '0;
            par_d   = rx_s_q;
            state_d = STOP;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (samp_q == SAMP_LAST) begin
            samp_d = '0;
            if (rx_s_q) begin
              // Returning at mid stop bit leaves half a bit to catch the next start edge.
              data_d  = shift_q;
              perr_d  = (PARITY != PAR_NONE) && par_bad;
              ovr_d   = valid_q && !data_ready;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      samp_q    <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      samp_q    <= samp_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  // Frame assembly registers; always reinitialised before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_16x.sv
// Scoreboard bench for uart_rx_16x: a plain 8-bit instance and an even-parity
// instance, both at a fast baud (4 clk per tick, 64 clk per bit).
module tb_uart_rx_16x;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 15_625;
  localparam int OS     = 16;
  localparam int BIT    = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx, rx_p;
  logic       data_ready, data_ready_p;
  logic [7:0] data_out, data_out_p;
  logic       data_valid, data_valid_p;
  logic       parity_err, parity_err_p;
  logic       frame_err, frame_err_p;
  logic       overrun, overrun_p;
  logic       busy, busy_p;

  always #5 clk = ~clk;

  uart_rx_16x #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy));

  uart_rx_16x #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(1)) dut_p (
    .clk(clk), .reset(reset), .rx(rx_p), .data_out(data_out_p), .data_valid(data_valid_p),
    .data_ready(data_ready_p), .parity_err(parity_err_p), .frame_err(frame_err_p),
    .overrun(overrun_p), .busy(busy_p));

  typedef struct {
    logic [7:0] d;
    logic       pe;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_pq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int last_lat  = -1;
  int ferr_cnt = 0, ovr_cnt = 0, ferr_cnt_p = 0, ovr_cnt_p = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (overrun) begin
        ovr_cnt++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (frame_err)   ferr_cnt++;
      if (overrun_p)   ovr_cnt_p++;
      if (frame_err_p) ferr_cnt_p++;
      if (data_valid && data_ready) begin
        last_lat = cyc - start_cyc;
        if (exp_q.size() == 0) check_eq("unexpected_byte", int'(data_out), -1);
        else begin
          e = exp_q.pop_front();
          check_eq("rx_data", int'(data_out), int'(e.d));
          check_eq("rx_perr", int'(parity_err), int'(e.pe));
        end
      end
      if (data_valid_p && data_ready_p) begin
        if (exp_pq.size() == 0) check_eq("unexpected_byte_p", int'(data_out_p), -1);
        else begin
          e = exp_pq.pop_front();
          check_eq("rxp_data", int'(data_out_p), int'(e.d));
          check_eq("rxp_perr", int'(parity_err_p), int'(e.pe));
        end
      end
    end
  end

  task automatic drive_bit(input bit inst, input logic v, input int clks);
    if (inst) rx_p = v;
    else      rx   = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  // par: -1 for no parity bit, otherwise the parity bit value to send
  task automatic send_frame(input bit inst, input logic [7:0] b, input int par, input logic stop);
    start_cyc = cyc;
    drive_bit(inst, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(inst, b[i], BIT);
    if (par >= 0) drive_bit(inst, par[0], BIT);
    drive_bit(inst, stop, BIT);
  endtask

  task automatic push(input bit inst, input logic [7:0] d, input logic pe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    if (inst) exp_pq.push_back(e);
    else      exp_q.push_back(e);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int f0, o0;
    logic [7:0] b6;
    reset = 1'b1; rx = 1'b1; rx_p = 1'b1; data_ready = 1'b1; data_ready_p = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data_out",   int'(data_out), 0);
    check_eq("rst_data_valid", int'(data_valid), 0);
    check_eq("rst_parity_err", int'(parity_err), 0);
    check_eq("rst_frame_err",  int'(frame_err), 0);
    check_eq("rst_overrun",    int'(overrun), 0);
    check_eq("rst_busy",       int'(busy), 0);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // 1: basic byte, ready held high
    push(0, 8'h41, 1'b0);
    send_frame(0, 8'h41, -1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("t1_latency_ok", int'(last_lat >= 600 && last_lat <= 620), 1);
    check_eq("t1_busy_idle", int'(busy), 0);
    check_eq("t1_ferr_cnt", ferr_cnt, 0);
    check_eq("t1_ovr_cnt", ovr_cnt, 0);

    // 2: false start, low pulse shorter than half a bit
    start_cyc = cyc;
    drive_bit(0, 1'b0, 20);
    check_eq("t2_busy_during", int'(busy), 1);
    drive_bit(0, 1'b1, 18);
    check_eq("t2_busy_after", int'(busy), 0);
    drive_bit(0, 1'b1, BIT * 2);
    check_eq("t2_ferr_cnt", ferr_cnt, 0);

    // 3: framing error, held-low line, then recovery
    f0 = ferr_cnt;
    send_frame(0, 8'h55, -1, 1'b0);
    drive_bit(0, 1'b0, BIT * 3);
    check_eq("t3_busy_break", int'(busy), 1);
    drive_bit(0, 1'b1, BIT);
    check_eq("t3_ferr_one", ferr_cnt - f0, 1);
    check_eq("t3_no_valid", int'(data_valid), 0);
    push(0, 8'h33, 1'b0);
    send_frame(0, 8'h33, -1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("t3_ferr_still_one", ferr_cnt - f0, 1);

    // 4: overrun with consumer stalled
    o0 = ovr_cnt;
    data_ready = 1'b0;
    push(0, 8'h12, 1'b0);
    send_frame(0, 8'h12, -1, 1'b1);
    push(0, 8'h34, 1'b0);
    send_frame(0, 8'h34, -1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("t4_valid_held", int'(data_valid), 1);
    check_eq("t4_data_out", int'(data_out), 'h34);
    check_eq("t4_ovr_one", ovr_cnt - o0, 1);
    data_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("t4_valid_drop", int'(data_valid), 0);

    // 5: even parity, wrong then correct parity bit
    push(1, 8'hA5, 1'b1);
    send_frame(1, 8'hA5, 1, 1'b1);
    push(1, 8'hA5, 1'b0);
    send_frame(1, 8'hA5, 0, 1'b1);
    push(1, 8'h07, 1'b0);
    send_frame(1, 8'h07, 1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("t5_busy_p", int'(busy_p), 0);

    // 6: reset during data bit 4
    b6 = 8'h7E;
    drive_bit(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(0, b6[i], BIT);
    drive_bit(0, b6[4], BIT / 2);
    check_eq("t6_busy_pre", int'(busy), 1);
    reset = 1'b1;
    #1;
    check_eq("t6_rst_data_out", int'(data_out), 0);
    check_eq("t6_rst_valid",    int'(data_valid), 0);
    check_eq("t6_rst_busy",     int'(busy), 0);
    check_eq("t6_rst_perr",     int'(parity_err), 0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    drive_bit(0, 1'b1, BIT);
    push(0, 8'h7E, 1'b0);
    send_frame(0, 8'h7E, -1, 1'b1);
    drive_bit(0, 1'b1, BIT);

    check_eq("final_q_empty",  exp_q.size(), 0);
    check_eq("final_pq_empty", exp_pq.size(), 0);
    check_eq("final_ferr_p",   ferr_cnt_p, 0);
    check_eq("final_ovr_p",    ovr_cnt_p, 0);
    check_eq("final_ferr",     ferr_cnt, 1);
    check_eq("final_ovr",      ovr_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
